cnn_mul_arb_9s_13s: RTL and testbench

//  Round-robin arbiter/scheduler sharing one signed 9b x 13b DSP48 multiplier

---
 rtl/cnn_mul_arb_pkg.sv | 13 +
 rtl/cnn_mul_arb_rr.sv | 42 ++++
 rtl/cnn_mul_mul_9s_13hbi_DSP48_1.sv | 14 +
 rtl/cnn_mul_arb_9s_13s.sv | 104 ++++++++++
 tb/tb_cnn_mul_arb_9s_13s.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_mul_arb_pkg.sv
// Shared widths, defaults and the operand record for the shared-DSP arbiter.
package cnn_mul_arb_pkg;
    localparam int A_W         = 9;
    localparam int B_W         = 13;
    localparam int P_W         = 23;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_MUL_LAT = 2;

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
    } opnd_t;
endpackage

// File: rtl/cnn_mul_arb_rr.sv
// Round-robin pointer plus rotate-priority one-hot picker.
module cnn_mul_arb_rr #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic            fire,
    output logic [ID_W-1:0] win_id
);
    logic [ID_W-1:0] ptr;
    int              idx;

    // First valid requester at or above the pointer, wrapping; nothing granted under hold or reset.
    always_comb begin
        grant  = '0;
        fire   = 1'b0;
        win_id = '0;
        idx    = 0;
        if (!hold && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!fire && valid[idx]) begin
                    fire       = 1'b1;
                    grant[idx] = 1'b1;
                    win_id     = ID_W'(idx);
                end
            end
        end
    end

    // Pointer moves just past the winner on every fire, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (fire)
            ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
endmodule

// File: rtl/cnn_mul_mul_9s_13hbi_DSP48_1.sv
// Signed 9b x 13b multiplier mapped onto one DSP slice; purely combinational.
module cnn_mul_mul_9s_13hbi_DSP48_1 (
    input  logic signed [8:0]  in0,
    input  logic signed [12:0] in1,
    output logic signed [22:0] dout
);
    logic signed [22:0] a_x;
    logic signed [22:0] b_x;

    // Sign-extend both operands to the product width so the low 23 bits are exact.
    assign a_x  = {{14{in0[8]}}, in0};
    assign b_x  = {{10{in1[12]}}, in1};
    assign dout = a_x * b_x;
endmodule

// File: rtl/cnn_mul_arb_9s_13s.sv
// Round-robin scheduler sharing one signed 9x13 multiplier among NREQ requesters.
// Stage 0 holds {id,a,b}; the product is then registered MUL_LAT-1 times.
module cnn_mul_arb_9s_13s
    import cnn_mul_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*A_W-1:0]    req_a,
    input  logic [NREQ*B_W-1:0]    req_b,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic signed [P_W-1:0]  res_p,
    output logic                   busy
);
    localparam int STAGES = MUL_LAT - 1;

    logic                       fire;
    logic [ID_W-1:0]            win_id;
    logic [NREQ-1:0]            grant;
    opnd_t                      in_op;
    opnd_t                      op_s0;
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][ID_W-1:0]  id_pipe;
    logic signed [P_W-1:0]      mul_p;

    cnn_mul_arb_rr #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .hold   (hold),
        .valid  (req_valid),
        .grant  (grant),
        .fire   (fire),
        .win_id (win_id)
    );

    assign req_ready = grant;

    // Steer the granted requester's operands toward stage 0 (grant is one-hot).
    always_comb begin
        in_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                in_op.a = req_a[i*A_W +: A_W];
                in_op.b = req_b[i*B_W +: B_W];
            end
        end
    end

    // Operand register plus id/valid shift chain; everything freezes under hold.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            op_s0    <= '0;
        end else if (!hold) begin
            vld_pipe[0] <= fire;
            id_pipe[0]  <= win_id;
            op_s0       <= in_op;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
        end
    end

    cnn_mul_mul_9s_13hbi_DSP48_1 u_mul (
        .in0  (op_s0.a),
        .in1  (op_s0.b),
        .dout (mul_p)
    );

    generate
        if (STAGES == 0) begin : g_no_preg
            assign res_p = mul_p;
        end else begin : g_preg
            logic [STAGES:1][P_W-1:0] p_pipe;

            // Product registers running alongside the id/valid chain.
            always_ff @(posedge ap_clk) begin
                if (ap_rst)
                    p_pipe <= '0;
                else if (!hold) begin
                    p_pipe[1] <= mul_p;
                    for (int k = 2; k <= STAGES; k++)
                        p_pipe[k] <= p_pipe[k-1];
                end
            end

            assign res_p = p_pipe[STAGES];
        end
    endgenerate

    // A frozen last stage is shown but not delivered until hold drops.
    assign res_valid = vld_pipe[STAGES] & ~hold;
    assign res_id    = id_pipe[STAGES];
    assign busy      = |vld_pipe;
endmodule

// File: tb/tb_cnn_mul_arb_9s_13s.sv
// Bench for cnn_mul_arb_9s_13s: operand table, hand sequences, randomized run vs. queue model.
module tb_cnn_mul_arb_9s_13s;
    localparam int N = 4;
    localparam int L = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic                hold;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*9-1:0]      req_a;
    logic [N*13-1:0]     req_b;
    logic                res_valid;
    logic [1:0]          res_id;
    logic signed [22:0]  res_p;
    logic                busy;

    cnn_mul_arb_9s_13s #(.NREQ(N), .MUL_LAT(L), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { int id; int p; int age; } ent_t;
    typedef struct { logic signed [8:0] a; logic signed [12:0] b; int p; } vec_t;

    ent_t   q[$];
    int     dlv[$];
    int     m_ptr = 0;
    int     checks = 0;
    int     errors = 0;
    bit     quiet = 1'b0;

    logic [N-1:0]        s_ready;
    logic                s_rv;
    logic [1:0]          s_id;
    logic signed [22:0]  s_p;
    logic                s_busy;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, sample mid-cycle, compare to model, advance model across the edge.
    task automatic tick(input logic r, input logic h, input logic [N-1:0] v,
                        input logic [N*9-1:0] av, input logic [N*13-1:0] bv);
        int win;
        bit front_out;
        logic [N-1:0] exp_ready;
        logic signed [8:0]  ta;
        logic signed [12:0] tb;
        ap_rst = r; hold = h; req_valid = v; req_a = av; req_b = bv;
        #4;
        s_ready = req_ready; s_rv = res_valid; s_id = res_id; s_p = res_p; s_busy = busy;
        win = -1;
        if (!r && !h)
            for (int k = 0; k < N; k++)
                if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        front_out = (q.size() > 0) && (q[0].age == L - 1);
        if (!quiet) begin
            chk("req_ready", s_ready, exp_ready);
            chk("res_valid", s_rv, front_out && !h);
            if (front_out) begin
                chk("res_id", s_id, q[0].id);
                chk("res_p", s_p, q[0].p);
            end
            chk("busy", s_busy, q.size() != 0);
        end
        if (s_rv) dlv.push_back(int'(s_id));
        if (r) begin
            q.delete();
            m_ptr = 0;
        end else if (!h) begin
            if (front_out) q.delete(0);
            foreach (q[j]) q[j].age++;
            if (win >= 0) begin
                ta = av[9*win +: 9];
                tb = bv[13*win +: 13];
                q.push_back('{win, int'(ta) * int'(tb), 0});
                m_ptr = (win + 1) % N;
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [N*9-1:0] rnd_a();
        logic [N*9-1:0] x;
        for (int i = 0; i < N; i++) x[9*i +: 9] = 9'($urandom());
        return x;
    endfunction

    function automatic logic [N*13-1:0] rnd_b();
        logic [N*13-1:0] x;
        for (int i = 0; i < N; i++) x[13*i +: 13] = 13'($urandom());
        return x;
    endfunction

    initial begin
        vec_t tbl[8];
        logic [N*9-1:0]  av;
        logic [N*13-1:0] bv;
        logic signed [22:0] hold_p;
        logic [1:0]         hold_id;
        int r;

        tbl[0] = '{9'sd3,    -13'sd5,    -15};
        tbl[1] = '{-9'sd256, -13'sd4096, 1048576};
        tbl[2] = '{9'sd255,  -13'sd4096, -1044480};
        tbl[3] = '{-9'sd256, 13'sd4095,  -1048320};
        tbl[4] = '{9'sd255,  13'sd4095,  1044225};
        tbl[5] = '{9'sd0,    -13'sd4096, 0};
        tbl[6] = '{-9'sd1,   -13'sd1,    1};
        tbl[7] = '{9'sd1,    -13'sd4096, -4096};

        ap_rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(posedge ap_clk);
        #1;
        quiet = 1'b1;
        do_reset();
        quiet = 1'b0;
        do_reset();

        // Reset state.
        idle(1);
        chk("rst_ready", s_ready, 0);
        chk("rst_res_valid", s_rv, 0);
        chk("rst_res_id", s_id, 0);
        chk("rst_res_p", s_p, 0);
        chk("rst_busy", s_busy, 0);

        // Operand table: one pair per requester in turn, result exactly two cycles after issue.
        for (int i = 0; i < 8; i++) begin
            r = i % N;
            av = '0; bv = '0;
            av[9*r +: 9]   = tbl[i].a;
            bv[13*r +: 13] = tbl[i].b;
            tick(1'b0, 1'b0, N'(1 << r), av, bv);
            chk("tbl_ready", s_ready, 1 << r);
            idle(1);
            chk("tbl_early", s_rv, 0);
            idle(1);
            chk("tbl_valid", s_rv, 1);
            chk("tbl_id", s_id, r);
            chk("tbl_p", s_p, tbl[i].p);
            chk("tbl_sign", s_p[22], s_p[21]);
        end

        // All requesters valid for 8 cycles: strict rotation, in-order results.
        do_reset();
        dlv.delete();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 4'hF, rnd_a(), rnd_b());
            chk("rot_ready", s_ready, 1 << (k % N));
            if (k >= 1) chk("rot_busy", s_busy, 1);
        end
        idle(3);
        chk("rot_count", dlv.size(), 8);
        for (int k = 0; k < 8 && k < dlv.size(); k++) chk("rot_order", dlv[k], k % N);

        // Pointer at 2 with only 0 and 3 valid: 3 first, then 0.
        do_reset();
        tick(1'b0, 1'b0, 4'b0010, rnd_a(), rnd_b());
        tick(1'b0, 1'b0, 4'b1001, rnd_a(), rnd_b());
        chk("ptr2_first", s_ready, 4'b1000);
        tick(1'b0, 1'b0, 4'b1001, rnd_a(), rnd_b());
        chk("ptr2_second", s_ready, 4'b0001);
        idle(3);

        // Three pairs then a 5-cycle hold: frozen outputs, each result delivered once.
        do_reset();
        dlv.delete();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'hF, rnd_a(), rnd_b());
        hold_p = '0; hold_id = '0;
        for (int h = 0; h < 5; h++) begin
            tick(1'b0, 1'b1, 4'hF, rnd_a(), rnd_b());
            chk("hold_ready", s_ready, 0);
            chk("hold_valid", s_rv, 0);
            if (h == 0) begin
                hold_p = s_p; hold_id = s_id;
            end else begin
                chk("hold_p_stable", s_p, hold_p);
                chk("hold_id_stable", s_id, hold_id);
            end
        end
        idle(3);
        chk("hold_count", dlv.size(), 3);
        for (int k = 0; k < 3 && k < dlv.size(); k++) chk("hold_order", dlv[k], k);

        // Reset with two pairs in flight drops them; first grant after goes to 0.
        do_reset();
        tick(1'b0, 1'b0, 4'hF, rnd_a(), rnd_b());
        tick(1'b0, 1'b0, 4'hF, rnd_a(), rnd_b());
        tick(1'b1, 1'b0, 4'hF, rnd_a(), rnd_b());
        chk("midrst_ready", s_ready, 0);
        idle(1);
        chk("midrst_valid", s_rv, 0);
        chk("midrst_busy", s_busy, 0);
        tick(1'b0, 1'b0, 4'hF, rnd_a(), rnd_b());
        chk("midrst_grant", s_ready, 4'b0001);
        idle(3);

        // Randomized traffic with holds and occasional resets against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++)
            tick(1'b0 | ($urandom_range(99) == 0), ($urandom_range(4) == 0),
                 4'($urandom()), rnd_a(), rnd_b());
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
